// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main-control FSM: fetch/decode/execute/memory/write-back sequencing.
// Optional macro MCFSM_ADDI_EN adds the ADDI_EX/ADDI_WB path for opcode 001000.
module mc_control_fsm #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemtoReg,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTYPE_EX = 4'd6,
        RTYPE_WB = 4'd7,
        BEQ      = 4'd8,
        JUMP     = 4'd9
`ifdef MCFSM_ADDI_EN
        ,
        ADDI_EX  = 4'd10,
        ADDI_WB  = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MCFSM_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    state_t cur, nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur <= FETCH;
        else       cur <= nxt;
    end

    always_comb begin
        nxt         = FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        case (cur)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                nxt     = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_RTYPE:     nxt = RTYPE_EX;
                    OP_BEQ:       nxt = BEQ;
                    OP_J:         nxt = JUMP;
`ifdef MCFSM_ADDI_EN
                    OP_ADDI:      nxt = ADDI_EX;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                        nxt        = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcB = 2'b10;
                nxt     = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                nxt     = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
                nxt        = mem_ready ? FETCH : MEMWR;
            end
            RTYPE_EX: begin
                ALUOp = 2'b10;
                nxt   = RTYPE_WB;
            end
            RTYPE_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            BEQ: begin
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
            end
            JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
`ifdef MCFSM_ADDI_EN
            ADDI_EX: begin
                ALUSrcB = 2'b10;
                nxt     = ADDI_WB;
            end
            ADDI_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
`endif
            default: nxt = FETCH;
        endcase

        // Reset silences every control combinationally so an aborted write never reaches memory.
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            MemtoReg    = 1'b0;
            IRWrite     = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ALUOp       = 2'b00;
            PCSource    = 2'b00;
            instr_done  = 1'b0;
            illegal_op  = 1'b0;
        end
    end

    assign state = reset ? '0 : STATE_W'(cur);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: vector table with scoreboard plus hand sequences
// for asynchronous reset aborts and randomised memory stalls.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic       RegDst, RegWrite, ALUSrcA, instr_done, illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;

    mc_control_fsm #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,RegDst,RegWrite,ALUSrcA,
    //  ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0],instr_done,illegal_op}
    logic [17:0] got_out;
    assign got_out = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                      RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op};

    localparam logic [17:0] O_ZERO      = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] O_FETCH_RDY = 18'b1_0_0_1_0_0_1_0_0_1_01_00_00_0_0;
    localparam logic [17:0] O_FETCH_STL = 18'b0_0_0_1_0_0_0_0_0_1_01_00_00_0_0;
    localparam logic [17:0] O_DECODE    = 18'b0_0_0_0_0_0_0_0_0_1_11_00_00_0_0;
    localparam logic [17:0] O_DECODE_IL = 18'b0_0_0_0_0_0_0_0_0_1_11_00_00_1_1;
    localparam logic [17:0] O_MEMADR    = 18'b0_0_0_0_0_0_0_0_0_0_10_00_00_0_0;
    localparam logic [17:0] O_MEMRD     = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] O_MEMWB     = 18'b0_0_0_0_0_1_0_0_1_0_00_00_00_1_0;
    localparam logic [17:0] O_MEMWR_RDY = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
    localparam logic [17:0] O_MEMWR_STL = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] O_RTEX      = 18'b0_0_0_0_0_0_0_0_0_0_00_10_00_0_0;
    localparam logic [17:0] O_RTWB      = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
    localparam logic [17:0] O_BEQ       = 18'b0_1_0_0_0_0_0_0_0_0_00_01_01_1_0;
    localparam logic [17:0] O_JUMP      = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
    localparam logic [17:0] O_ADDIEX    = 18'b0_0_0_0_0_0_0_0_0_0_10_00_00_0_0;
    localparam logic [17:0] O_ADDIWB    = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [17:0] out;
    } vec_t;

    typedef struct {
        int          idx;
        logic [3:0]  st;
        logic [17:0] out;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   lat_sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic [5:0] op, input logic rdy,
                       input logic [3:0] st, input logic [17:0] out);
        vec_t v;
        v.rst = r; v.op = op; v.rdy = rdy; v.st = st; v.out = out;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic sched(input int k, input int f, input int m);
        if (k < f)             return 1'b0;
        if (k == f)            return 1'b1;
        if (k <= f + 2)        return 1'($urandom_range(1));
        if (k < f + 3 + m)     return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int   f, m, done_at, pulses, k;
        logic [3:0] st_after;

        reset = 1'b1; opcode = 6'b000000; mem_ready = 1'b0;

        // reset state
        @(negedge clk);
        check("reset state", 32'(state), 32'd0);
        check("reset outs", 32'(got_out), 32'(O_ZERO));

        // R-type interrupted by asynchronous reset in RTYPE_EX
        @(posedge clk); #1 reset = 1'b0; opcode = 6'b000000; mem_ready = 1'b1;
        @(negedge clk); check("A fetch st", 32'(state), 32'd0);
        check("A fetch out", 32'(got_out), 32'(O_FETCH_RDY));
        @(negedge clk); check("A decode st", 32'(state), 32'd1);
        @(negedge clk); check("A rtex st", 32'(state), 32'd6);
        check("A rtex out", 32'(got_out), 32'(O_RTEX));
        #1 reset = 1'b1;
        #1 check("A async st", 32'(state), 32'd0);
        check("A async out", 32'(got_out), 32'(O_ZERO));
        @(negedge clk); check("A held st", 32'(state), 32'd0);
        check("A held out", 32'(got_out), 32'(O_ZERO));

        // vector table: one entry per clock cycle
        add(1, 6'b000000, 1, 4'd0, O_ZERO);
        add(0, 6'b000000, 1, 4'd0, O_FETCH_RDY);
        add(0, 6'b000000, 1, 4'd1, O_DECODE);
        add(0, 6'b000000, 1, 4'd6, O_RTEX);
        add(0, 6'b000000, 1, 4'd7, O_RTWB);
        add(0, 6'b100011, 0, 4'd0, O_FETCH_STL);
        add(0, 6'b100011, 0, 4'd0, O_FETCH_STL);
        add(0, 6'b100011, 1, 4'd0, O_FETCH_RDY);
        add(0, 6'b100011, 0, 4'd1, O_DECODE);
        add(0, 6'b100011, 0, 4'd2, O_MEMADR);
        add(0, 6'b100011, 0, 4'd3, O_MEMRD);
        add(0, 6'b100011, 0, 4'd3, O_MEMRD);
        add(0, 6'b100011, 0, 4'd3, O_MEMRD);
        add(0, 6'b100011, 1, 4'd3, O_MEMRD);
        add(0, 6'b100011, 1, 4'd4, O_MEMWB);
        add(0, 6'b101011, 1, 4'd0, O_FETCH_RDY);
        add(0, 6'b101011, 1, 4'd1, O_DECODE);
        add(0, 6'b101011, 1, 4'd2, O_MEMADR);
        add(0, 6'b101011, 0, 4'd5, O_MEMWR_STL);
        add(0, 6'b101011, 1, 4'd5, O_MEMWR_RDY);
        add(0, 6'b000100, 1, 4'd0, O_FETCH_RDY);
        add(0, 6'b000100, 1, 4'd1, O_DECODE);
        add(0, 6'b000100, 1, 4'd8, O_BEQ);
        add(0, 6'b000010, 1, 4'd0, O_FETCH_RDY);
        add(0, 6'b000010, 1, 4'd1, O_DECODE);
        add(0, 6'b000010, 1, 4'd9, O_JUMP);
        add(0, 6'b111111, 1, 4'd0, O_FETCH_RDY);
        add(0, 6'b111111, 1, 4'd1, O_DECODE_IL);
        add(0, 6'b001000, 1, 4'd0, O_FETCH_RDY);
`ifdef MCFSM_ADDI_EN
        add(0, 6'b001000, 1, 4'd1, O_DECODE);
        add(0, 6'b001000, 1, 4'd10, O_ADDIEX);
        add(0, 6'b001000, 1, 4'd11, O_ADDIWB);
`else
        add(0, 6'b001000, 1, 4'd1, O_DECODE_IL);
`endif
        add(0, 6'b000000, 1, 4'd0, O_FETCH_RDY);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            reset = vecs[i].rst; opcode = vecs[i].op; mem_ready = vecs[i].rdy;
            e.idx = i; e.st = vecs[i].st; e.out = vecs[i].out;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            check($sformatf("vec%0d state", e.idx), 32'(state), 32'(e.st));
            check($sformatf("vec%0d outs", e.idx), 32'(got_out), 32'(e.out));
        end

        // sw aborted by reset while MemWrite is asserted
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; opcode = 6'b101011; mem_ready = 1'b1;
        @(negedge clk); check("B fetch st", 32'(state), 32'd0);
        @(negedge clk); check("B decode st", 32'(state), 32'd1);
        @(negedge clk); check("B memadr st", 32'(state), 32'd2);
        @(posedge clk); #1 mem_ready = 1'b0;
        @(negedge clk); check("B memwr out", 32'(got_out), 32'(O_MEMWR_STL));
        #1 reset = 1'b1; mem_ready = 1'b1;
        #1 check("B abort st", 32'(state), 32'd0);
        check("B abort MemWrite", 32'(MemWrite), 32'd0);
        check("B abort outs", 32'(got_out), 32'(O_ZERO));
        @(posedge clk); #1 check("B edge st", 32'(state), 32'd0);
        check("B edge outs", 32'(got_out), 32'(O_ZERO));

        // lw with random stall counts: bounded wait for instr_done
        for (int t = 0; t < 4; t++) begin
            f = $urandom_range(3);
            m = $urandom_range(4);
            @(posedge clk); #1 reset = 1'b1;
            @(posedge clk); #1 reset = 1'b0; opcode = 6'b100011;
            lat_sb.push_back(f + m + 4);
            k = 0; done_at = -1; pulses = 0; st_after = 4'hF;
            while (k < 60) begin
                mem_ready = sched(k, f, m);
                @(negedge clk);
                if (instr_done) begin
                    pulses++;
                    if (done_at < 0) done_at = k;
                end
                if (done_at >= 0 && k == done_at + 1) begin
                    st_after = state;
                    break;
                end
                @(posedge clk); #1;
                k++;
            end
            check($sformatf("C%0d done cycle f%0d m%0d", t, f, m), 32'(done_at), 32'(lat_sb.pop_front()));
            check($sformatf("C%0d done pulses", t), 32'(pulses), 32'd1);
            check($sformatf("C%0d state after", t), 32'(st_after), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multicycle main-control state machine for the MIPS datapath. Sequences fetch, decode, execute, memory and write-back by driving the datapath enables and mux selects from the current state and the latched opcode. Replaces the free-running opcode decoder with a resettable FSM that stalls on a memory-ready handshake and flags unsupported opcodes.

## Interface
Parameters:
- `STATE_W`, default 4: width of the `state` debug output.

Ports:
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-high; forces state to FETCH.
- `opcode` input 6: IR[31:26]; sampled only in DECODE.
- `mem_ready` input 1: memory completes the current access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `RegDst`, `RegWrite`, `ALUSrcA` output 1 each: datapath controls.
- `ALUSrcB`, `ALUOp`, `PCSource` output 2 each: datapath selects.
- `instr_done` output 1: last cycle of the current instruction.
- `illegal_op` output 1: unsupported opcode detected in DECODE.
- `state` output STATE_W: current state encoding.

## Operation
- Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPE_EX=6, RTYPE_WB=7, BEQ=8, JUMP=9, ADDI_EX=10, ADDI_WB=11. Codes 12-15 are unreachable; if entered, go to FETCH.
- Mux polarity follows the datapath. `ALUSrcA` 1 selects PC and 0 selects register A. `ALUSrcB` 00 selects B, 01 selects 4, 10 selects sign-extended immediate, 11 selects shifted immediate. `PCSource` 00 selects ALU, 01 selects ALUout, 10 selects jump target.
- Any output not listed for a state is 0.
- FETCH:
  - Drives MemRead=1, ALUSrcA=1, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite equal `mem_ready`.
  - Next state is DECODE if `mem_ready`, otherwise FETCH.
- DECODE:
  - Drives ALUSrcA=1, ALUSrcB=11, ALUOp=00.
  - Next state by opcode: 100011/101011 to MEMADR, 000000 to RTYPE_EX, 000100 to BEQ, 000010 to JUMP, 001000 to ADDI_EX (macro only).
  - Any other opcode: illegal_op=1, instr_done=1, next state FETCH.
- MEMADR: ALUSrcA=0, ALUSrcB=10, ALUOp=00. Next is MEMRD for lw (opcode 100011), MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Next FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until `mem_ready`; instr_done=`mem_ready`; then FETCH.
- RTYPE_EX: ALUSrcA=0, ALUSrcB=00, ALUOp=10. Next RTYPE_WB.
- RTYPE_WB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. Next FETCH.
- BEQ: ALUSrcA=0, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. Next FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1. Next FETCH.
- ADDI_EX: ALUSrcA=0, ALUSrcB=10, ALUOp=00. Next ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1. Next FETCH.
- The opcode is used only in DECODE and MEMADR, while IR is stable. The FSM holds no opcode copy.

## Timing
- State register updates on rising `clk`. Outputs decode combinationally from state and `mem_ready` (Moore, plus `mem_ready` gating).
- While `reset`=1, all outputs are 0 (including `instr_done`, `illegal_op`) and `state`=0, regardless of `clk`.
- Reset asserted mid-instruction aborts it immediately. No partial write is issued after the reset edge.
- After `reset` deasserts, the first rising edge evaluates FETCH normally.
- Latency with `mem_ready` held at 1: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal 2 cycles.
- Each low `mem_ready` cycle in FETCH, MEMRD or MEMWR adds exactly one cycle. Outputs stay constant during a stall, except the gated IRWrite/PCWrite/instr_done.
- `instr_done` is asserted for exactly one cycle per instruction.

## Configuration
- `MCFSM_ADDI_EN`:
  - Defined: opcode 001000 decodes to ADDI_EX then ADDI_WB.
  - Undefined: ADDI states are not compiled, and opcode 001000 takes the illegal path (illegal_op=1 in DECODE, back to FETCH).

## Test plan
- Reset then R-type: assert reset mid-RTYPE_EX → state=0 and all outputs 0 immediately. Release, opcode=000000, mem_ready=1 → states 0,1,6,7,0; RegWrite=1 with RegDst=1 only in cycle 4; instr_done pulses once.
- lw with stalls: opcode=100011, mem_ready low for 2 cycles in FETCH and 3 in MEMRD → IRWrite/PCWrite high only on the ready FETCH cycle; total 10 cycles; MemtoReg=1 in MEMWB.
- sw: opcode=101011, mem_ready=1 → states 0,1,2,5,0; MemWrite=1 and IorD=1 for one cycle; RegWrite never asserted.
- beq and j: opcode=000100 → PCWriteCond=1 with PCSource=01 in cycle 3. opcode=000010 → PCWrite=1 with PCSource=10 in cycle 3.
- Illegal: opcode=111111 → illegal_op=1 and instr_done=1 in DECODE; next state 0; no RegWrite/MemWrite.
- addi: opcode=001000 → with `MCFSM_ADDI_EN` states 0,1,10,11,0 with ALUSrcB=10 in state 10; without it, illegal_op=1 in DECODE.
